// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin front end that lets two requesters share one
// external combinational barrel shifter. Each accepted op is captured, run
// through the shifter for one cycle, and returned on the owner's response
// channel before the next request is considered.
module shift_arbiter #(
    parameter int DWIDTH    = 16,
    parameter int SHIFT_NUM = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DWIDTH-1:0]    req0_data,
    input  logic [SHIFT_NUM-1:0] req0_shamt,
    input  logic                 req0_l_r,
    input  logic                 req0_a_l,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DWIDTH-1:0]    req1_data,
    input  logic [SHIFT_NUM-1:0] req1_shamt,
    input  logic                 req1_l_r,
    input  logic                 req1_a_l,

    output logic                 resp0_valid,
    input  logic                 resp0_ready,
    output logic [DWIDTH-1:0]    resp0_data,

    output logic                 resp1_valid,
    input  logic                 resp1_ready,
    output logic [DWIDTH-1:0]    resp1_data,

    output logic [DWIDTH-1:0]    sh_data_i,
    output logic [SHIFT_NUM-1:0] sh_shamt,
    output logic                 sh_l_r,
    output logic                 sh_a_l,
    input  logic [DWIDTH-1:0]    sh_data_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic                   last_grant;
    logic                   owner;
    logic                   grant;
    logic                   any_req;
    logic                   accept;
    logic                   resp_done;

    logic [DWIDTH-1:0]      op_data_p0;
    logic [SHIFT_NUM-1:0]   op_shamt_p0;
    logic                   op_l_r_p0;
    logic                   op_a_l_p0;
    logic [DWIDTH-1:0]      result_p1;

    // Round-robin pick: a lone requester always wins, a tie goes to the one
    // that was not served last.
    always_comb begin
        any_req = req0_valid | req1_valid;
        grant   = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Next-state decode and handshake outputs. Requests are only offered in
    // IDLE, so response completion never feeds request acceptance in the same
    // cycle.
    always_comb begin
        state_next  = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        accept      = 1'b0;
        resp_done   = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        case (state)
            IDLE: begin
                accept     = any_req;
                req0_ready = any_req && !grant;
                req1_ready = any_req && grant;
                if (any_req) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                resp0_valid = !owner;
                resp1_valid = owner;
                resp_done   = owner ? resp1_ready : resp0_ready;
                if (resp_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration history and ownership of the op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
        end else if (accept) begin
            last_grant <= grant;
            owner      <= grant;
        end
    end

    // Stage p0: operand capture from the granted requester on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_data_p0  <= '0;
            op_shamt_p0 <= '0;
            op_l_r_p0   <= 1'b0;
            op_a_l_p0   <= 1'b0;
        end else if (accept) begin
            if (grant) begin
                op_data_p0  <= req1_data;
                op_shamt_p0 <= req1_shamt;
                op_l_r_p0   <= req1_l_r;
                op_a_l_p0   <= req1_a_l;
            end else begin
                op_data_p0  <= req0_data;
                op_shamt_p0 <= req0_shamt;
                op_l_r_p0   <= req0_l_r;
                op_a_l_p0   <= req0_a_l;
            end
        end
    end

    // The shifter only ever sees registered operands, giving it a full cycle.
    assign sh_data_i = op_data_p0;
    assign sh_shamt  = op_shamt_p0;
    assign sh_l_r    = op_l_r_p0;
    assign sh_a_l    = op_a_l_p0;

    // Stage p1: shifter output captured at the end of EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_p1 <= '0;
        end else if (state == EXEC) begin
            result_p1 <= sh_data_o;
        end
    end

    // Result is exposed only to the owner while its response is pending.
    assign resp0_data = resp0_valid ? result_p1 : '0;
    assign resp1_data = resp1_valid ? result_p1 : '0;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed and randomized checks of shift_arbiter, with a
// behavioural barrel shifter on the sh_* ports and a queue-based reference.
module tb_shift_arbiter;

    localparam int DW = 16;
    localparam int SN = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_l_r, req0_a_l;
    logic [DW-1:0] req0_data;
    logic [SN-1:0] req0_shamt;
    logic          req1_valid, req1_ready, req1_l_r, req1_a_l;
    logic [DW-1:0] req1_data;
    logic [SN-1:0] req1_shamt;
    logic          resp0_valid, resp0_ready;
    logic [DW-1:0] resp0_data;
    logic          resp1_valid, resp1_ready;
    logic [DW-1:0] resp1_data;
    logic [DW-1:0] sh_data_i, sh_data_o;
    logic [SN-1:0] sh_shamt;
    logic          sh_l_r, sh_a_l;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.DWIDTH(DW), .SHIFT_NUM(SN)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_shamt(req0_shamt), .req0_l_r(req0_l_r), .req0_a_l(req0_a_l),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_shamt(req1_shamt), .req1_l_r(req1_l_r), .req1_a_l(req1_a_l),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
        .sh_data_i(sh_data_i), .sh_shamt(sh_shamt), .sh_l_r(sh_l_r), .sh_a_l(sh_a_l),
        .sh_data_o(sh_data_o)
    );

    // Stand-in for the external barrel shifter.
    always_comb begin
        if (sh_l_r)      sh_data_o = sh_data_i << sh_shamt;
        else if (sh_a_l) sh_data_o = $unsigned($signed(sh_data_i) >>> sh_shamt);
        else             sh_data_o = sh_data_i >> sh_shamt;
    end

    // Reference: shift inside a 32-bit window whose upper half is fill bits.
    function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] d, input logic [SN-1:0] s,
                                                input logic lr, input logic al);
        logic [2*DW-1:0] w;
        if (lr) begin
            w = {{DW{1'b0}}, d} << s;
        end else begin
            w = {((al && d[DW-1]) ? {DW{1'b1}} : {DW{1'b0}}), d} >> s;
        end
        return w[DW-1:0];
    endfunction

    task automatic clear_inputs();
        req0_valid = 0; req0_data = '0; req0_shamt = '0; req0_l_r = 0; req0_a_l = 0;
        req1_valid = 0; req1_data = '0; req1_shamt = '0; req1_l_r = 0; req1_a_l = 0;
        resp0_ready = 0; resp1_ready = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic drain();
        req0_valid = 0; req1_valid = 0;
        resp0_ready = 1; resp1_ready = 1;
        repeat (5) @(negedge clk);
    endtask

    // Issue one op on port p with response ready held high; report result,
    // samples from accept to response, whether the other port responded, and
    // whether a response arrived within the bound.
    task automatic run_op(input bit p, input logic [DW-1:0] d, input logic [SN-1:0] s,
                          input bit lr, input bit al, output logic [DW-1:0] res,
                          output int lat, output bit other, output bit ok);
        int n;
        ok = 0; other = 0; lat = 0; res = '0;
        @(negedge clk);
        resp0_ready = 1; resp1_ready = 1;
        if (p) begin
            req1_valid = 1; req1_data = d; req1_shamt = s; req1_l_r = lr; req1_a_l = al;
        end else begin
            req0_valid = 1; req0_data = d; req0_shamt = s; req0_l_r = lr; req0_a_l = al;
        end
        #1;
        n = 0;
        while (!(p ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n < 20) begin
            @(negedge clk);
            req0_valid = 0; req1_valid = 0;
            #1;
            lat = 1;
            while (!(p ? resp1_valid : resp0_valid) && lat < 10) begin
                if (p ? resp0_valid : resp1_valid) other = 1;
                @(negedge clk); #1; lat++;
            end
            if (p ? resp0_valid : resp1_valid) other = 1;
            if (p ? resp1_valid : resp0_valid) begin
                res = p ? resp1_data : resp0_data;
                ok  = 1;
            end
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_reset();
        logic [57:0] outs;
        apply_reset();
        #1;
        outs = {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_data, resp1_data,
                sh_data_i, sh_shamt, sh_l_r, sh_a_l};
        compared++;
        if (outs !== '0) begin
            mismatched++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        req0_valid = 1; req1_valid = 1;
        #1;
        compared++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            mismatched++; $display("FAIL reset_first_tie: got %b expected 10", {req0_ready, req1_ready});
        end
        req0_valid = 0; req1_valid = 0;
        #1;
    endtask

    task automatic test_left_shift();
        logic [DW-1:0] res; int lat; bit oth, ok;
        run_op(0, 16'h8001, 4'd1, 1, 0, res, lat, oth, ok);
        compared++;
        if (!ok || res !== 16'h0002) begin
            mismatched++; $display("FAIL left_result: got %h (ok=%0d) expected 0002", res, ok);
        end
        compared++;
        if (lat != 2) begin
            mismatched++; $display("FAIL left_latency: got %0d expected 2", lat);
        end
        compared++;
        if (oth) begin
            mismatched++; $display("FAIL left_other_resp: got 1 expected 0");
        end
    endtask

    task automatic test_right_shift();
        logic [DW-1:0] res; int lat; bit oth, ok;
        run_op(1, 16'h8000, 4'd4, 0, 1, res, lat, oth, ok);
        compared++;
        if (!ok || oth || res !== 16'hF800) begin
            mismatched++; $display("FAIL right_arith: got %h ok=%0d other=%0d expected F800", res, ok, oth);
        end
        run_op(1, 16'h8000, 4'd4, 0, 0, res, lat, oth, ok);
        compared++;
        if (!ok || oth || res !== 16'h0800) begin
            mismatched++; $display("FAIL right_logic: got %h ok=%0d other=%0d expected 0800", res, ok, oth);
        end
        run_op(1, 16'h8000, 4'd0, 0, 1, res, lat, oth, ok);
        compared++;
        if (!ok || oth || res !== 16'h8000) begin
            mismatched++; $display("FAIL shamt_zero: got %h ok=%0d other=%0d expected 8000", res, ok, oth);
        end
        run_op(0, 16'hC3A5, 4'd3, 1, 1, res, lat, oth, ok);
        compared++;
        if (!ok || res !== 16'h1D28) begin
            mismatched++; $display("FAIL left_ignores_al: got %h expected 1D28", res);
        end
    endtask

    task automatic test_alternation();
        int grants[$];
        int n;
        logic [DW-1:0] res; int lat; bit oth, ok;
        apply_reset();
        @(negedge clk);
        resp0_ready = 1; resp1_ready = 1;
        req0_valid = 1; req0_data = 16'h1234; req0_shamt = 4'd2; req0_l_r = 1; req0_a_l = 0;
        req1_valid = 1; req1_data = 16'h4321; req1_shamt = 4'd1; req1_l_r = 0; req1_a_l = 0;
        n = 0;
        while (grants.size() < 4 && n < 60) begin
            #1;
            if (req0_valid && req0_ready) grants.push_back(0);
            else if (req1_valid && req1_ready) grants.push_back(1);
            @(negedge clk);
            n++;
        end
        req0_valid = 0; req1_valid = 0;
        if (grants.size() < 4) begin
            compared++; mismatched++;
            $display("FAIL alternation_timeout: got %0d grants expected 4", grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                compared++;
                if (grants[i] != (i % 2)) begin
                    mismatched++; $display("FAIL alternation_%0d: got %0d expected %0d", i, grants[i], i % 2);
                end
            end
        end
        drain();
        run_op(0, 16'h00F0, 4'd4, 1, 0, res, lat, oth, ok);
        compared++;
        if (!ok || oth || res !== ref_shift(16'h00F0, 4'd4, 1, 0)) begin
            mismatched++; $display("FAIL b2b_first: got %h ok=%0d expected %h", res, ok, ref_shift(16'h00F0, 4'd4, 1, 0));
        end
        run_op(0, 16'hF00F, 4'd8, 0, 1, res, lat, oth, ok);
        compared++;
        if (!ok || oth || res !== ref_shift(16'hF00F, 4'd8, 0, 1)) begin
            mismatched++; $display("FAIL b2b_second: got %h ok=%0d expected %h", res, ok, ref_shift(16'hF00F, 4'd8, 0, 1));
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d0, exp0, exp1;
        int n;
        @(negedge clk);
        resp0_ready = 0; resp1_ready = 0;
        req0_valid = 1; req0_data = 16'hA5C3; req0_shamt = 4'd3; req0_l_r = 0; req0_a_l = 1;
        exp0 = ref_shift(16'hA5C3, 4'd3, 0, 1);
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 1; req1_data = 16'h0F0F; req1_shamt = 4'd5; req1_l_r = 1; req1_a_l = 1;
        exp1 = ref_shift(16'h0F0F, 4'd5, 1, 1);
        #1;
        n = 0;
        while (!resp0_valid && n < 20) begin @(negedge clk); #1; n++; end
        d0 = resp0_data;
        compared++;
        if (!resp0_valid || d0 !== exp0) begin
            mismatched++; $display("FAIL bp_result: got %h valid=%0d expected %h", d0, resp0_valid, exp0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            compared++;
            if ({resp0_valid, resp0_data, req0_ready, req1_ready, resp1_valid} !== {1'b1, exp0, 3'b000}) begin
                mismatched++;
                $display("FAIL bp_hold_%0d: got v=%0d d=%h r0=%0d r1=%0d v1=%0d expected v=1 d=%h rdy=0",
                         i, resp0_valid, resp0_data, req0_ready, req1_ready, resp1_valid, exp0);
            end
        end
        @(negedge clk);
        resp0_ready = 1;
        #1;
        compared++;
        if (req1_ready !== 1'b0) begin
            mismatched++; $display("FAIL bp_no_same_cycle_accept: got %0d expected 0", req1_ready);
        end
        @(negedge clk); #1;
        compared++;
        if ({resp0_valid, req1_ready} !== 2'b01) begin
            mismatched++; $display("FAIL bp_idle_after: got %b expected 01", {resp0_valid, req1_ready});
        end
        @(negedge clk);
        req1_valid = 0; resp1_ready = 1;
        #1;
        n = 0;
        while (!resp1_valid && n < 20) begin @(negedge clk); #1; n++; end
        compared++;
        if (!resp1_valid || resp1_data !== exp1) begin
            mismatched++; $display("FAIL bp_queued_req1: got %h valid=%0d expected %h", resp1_data, resp1_valid, exp1);
        end
        drain();
    endtask

    task automatic test_reset_exec();
        logic [57:0] outs;
        int n, pulses;
        @(negedge clk);
        resp0_ready = 1; resp1_ready = 1;
        req0_valid = 1; req0_data = 16'hFFFF; req0_shamt = 4'd7; req0_l_r = 0; req0_a_l = 1;
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        req0_valid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        outs = {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_data, resp1_data,
                sh_data_i, sh_shamt, sh_l_r, sh_a_l};
        compared++;
        if (outs !== '0) begin
            mismatched++; $display("FAIL rst_exec_outputs: got %h expected 0", outs);
        end
        pulses = 0;
        repeat (5) begin
            @(negedge clk); #1;
            if (resp0_valid || resp1_valid) pulses++;
        end
        compared++;
        if (pulses != 0) begin
            mismatched++; $display("FAIL rst_exec_no_resp: got %0d pulses expected 0", pulses);
        end
        @(negedge clk);
        req0_valid = 1; req1_valid = 1;
        #1;
        compared++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            mismatched++; $display("FAIL rst_exec_rearb: got %b expected 10", {req0_ready, req1_ready});
        end
        @(negedge clk);
        drain();
    endtask

    typedef struct packed {
        logic          p;
        logic [DW-1:0] r;
    } exp_t;

    task automatic test_random();
        exp_t          q[$];
        logic [DW-1:0] od[2];
        logic [SN-1:0] os[2];
        logic          ol[2], oa[2];
        bit            pend[2];
        bit            last_g;
        int            accepted, responses, cycles;
        logic          rv, rr;
        logic [DW-1:0] rd;
        apply_reset();
        pend[0] = 0; pend[1] = 0;
        last_g = 1;
        accepted = 0; responses = 0; cycles = 0;
        while (responses < 1000 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && accepted < 1000 && $urandom_range(3) != 0) begin
                    od[p] = 16'($urandom);
                    os[p] = 4'($urandom_range(15));
                    ol[p] = 1'($urandom_range(1));
                    oa[p] = 1'($urandom_range(1));
                    pend[p] = 1;
                end
            end
            req0_valid = pend[0]; req0_data = od[0]; req0_shamt = os[0]; req0_l_r = ol[0]; req0_a_l = oa[0];
            req1_valid = pend[1]; req1_data = od[1]; req1_shamt = os[1]; req1_l_r = ol[1]; req1_a_l = oa[1];
            resp0_ready = ($urandom_range(2) != 0);
            resp1_ready = ($urandom_range(2) != 0);
            #1;
            if (req0_ready && req1_ready) begin
                compared++; mismatched++; $display("FAIL rnd_dual_ready: cycle %0d got 11 expected one-hot", cycles);
            end
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) begin
                    compared++;
                    if (pend[0] && pend[1] && p == int'(last_g)) begin
                        mismatched++; $display("FAIL rnd_grant: cycle %0d got %0d expected %0d", cycles, p, !last_g);
                    end
                    q.push_back({1'(p), ref_shift(od[p], os[p], ol[p], oa[p])});
                    last_g = 1'(p);
                    pend[p] = 0;
                    accepted++;
                end
            end
            if (resp0_valid && resp1_valid) begin
                compared++; mismatched++; $display("FAIL rnd_dual_resp: cycle %0d got both valid expected one", cycles);
            end else if (resp0_valid || resp1_valid) begin
                rv = resp1_valid;
                rd = rv ? resp1_data : resp0_data;
                rr = rv ? resp1_ready : resp0_ready;
                compared++;
                if (q.size() == 0) begin
                    mismatched++; $display("FAIL rnd_spurious_resp: cycle %0d port %0d got %h expected none", cycles, rv, rd);
                end else begin
                    if (q[0].p !== rv || q[0].r !== rd) begin
                        mismatched++;
                        $display("FAIL rnd_resp: cycle %0d got port %0d data %h expected port %0d data %h",
                                 cycles, rv, rd, q[0].p, q[0].r);
                    end
                    if (rr) begin
                        void'(q.pop_front());
                        responses++;
                    end
                end
            end
        end
        compared++;
        if (responses != 1000 || accepted != 1000 || q.size() != 0) begin
            mismatched++;
            $display("FAIL rnd_totals: got accepted %0d responses %0d pending %0d expected 1000/1000/0",
                     accepted, responses, q.size());
        end
        drain();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_left_shift();
        test_right_shift();
        test_alternation();
        test_backpressure();
        test_reset_exec();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
